// File: rtl/bft_stream_sender.sv
// Packs a producer word stream into BFT packets for one (leaf, port) input, after a one-shot config packet.
// Latency: one cycle from an acked word to its packet on dout_sender2bft. The config packet goes out on the first cycle after reset.
// Backpressure: same-cycle ack from freespace credits, which the receiver returns over the BFT. Producer is stalled at zero credit.
module bft_stream_sender #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int DST_LEAF              = 2,
  parameter int DST_PORT              = 2,
  parameter int SELF_LEAF             = 1,
  parameter int SELF_PORT             = 1
) (
  input  logic                    clk_bft,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_leaf_user2sender,
  input  logic                    vld_user2sender,
  output logic                    ack_sender2user,
  output logic [PACKET_BITS-1:0]  dout_sender2bft,
  input  logic [PACKET_BITS-1:0]  din_bft2sender,
  output logic [7:0]              credit_avail,
  output logic                    stalled,
  output logic                    err_credit_ovf
);

  // The credit counter must hold the full receiver depth, so it needs one bit more than the BRAM address.
  localparam int CW      = NUM_BRAM_ADDR_BITS + 1;
  localparam int CFG_PAD = PAYLOAD_BITS - 2*NUM_PORT_BITS - NUM_LEAF_BITS;

  localparam logic [CW:0]   CREDIT_MAX_W = (CW+1)'(2**NUM_BRAM_ADDR_BITS);
  localparam logic [CW-1:0] CREDIT_MAX   = CW'(2**NUM_BRAM_ADDR_BITS);
  localparam logic [CW:0]   CREDIT_STEP  = (CW+1)'(FREESPACE_UPDATE_SIZE);

  typedef struct packed {
    logic                     vld;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } pkt_t;

  // A credit return is recognised by its header alone. The address and payload of that packet carry no meaning for us.
  localparam logic [PACKET_BITS-1:0] RET_MASK = {1'b1, {NUM_LEAF_BITS{1'b1}}, {NUM_PORT_BITS{1'b1}},
                                                 {NUM_ADDR_BITS{1'b0}}, {PAYLOAD_BITS{1'b0}}};
  localparam logic [PACKET_BITS-1:0] RET_MATCH = {1'b1, NUM_LEAF_BITS'(SELF_LEAF), NUM_PORT_BITS'(SELF_PORT),
                                                  {NUM_ADDR_BITS{1'b0}}, {PAYLOAD_BITS{1'b0}}};

  // The config packet tells the receiving leaf which of its ports is fed and where freespace credits go back to.
  localparam logic [PACKET_BITS-1:0] CFG_PKT = {1'b1, NUM_LEAF_BITS'(DST_LEAF), {NUM_PORT_BITS{1'b0}},
                                                {NUM_ADDR_BITS{1'b0}}, {CFG_PAD{1'b0}},
                                                NUM_PORT_BITS'(DST_PORT), NUM_LEAF_BITS'(SELF_LEAF),
                                                NUM_PORT_BITS'(SELF_PORT)};

  typedef enum logic [1:0] {
    ST_CFG     = 2'd0,
    ST_RUN     = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_credit;
  logic [NUM_ADDR_BITS-1:0] r_addr;
  pkt_t               r_dout;
  logic               r_ovf;

  logic               w_ret;
  logic               w_ack;
  logic               w_stalled;
  logic [CW:0]        w_credit_sum;
  logic               w_credit_ovf;
  logic [CW-1:0]      w_credit_nxt;
  pkt_t               w_data_pkt;

  assign w_ret = ((din_bft2sender & RET_MASK) == RET_MATCH);

  // Same-cycle handshake. Gating with reset keeps the producer from seeing an ack while a reset is being applied.
  assign w_ack     = !reset && (r_state == ST_RUN) && vld_user2sender && (r_credit != '0);
  assign w_stalled = !reset && (r_state == ST_BLOCKED) && vld_user2sender;

  assign w_data_pkt = '{vld:     1'b1,
                        leaf:    NUM_LEAF_BITS'(DST_LEAF),
                        port:    NUM_PORT_BITS'(DST_PORT),
                        addr:    r_addr,
                        payload: din_leaf_user2sender};

  // Next credit value: add the returned freespace, subtract the word being sent, and clamp at the receiver depth.
  always_comb begin
    w_credit_sum = {1'b0, r_credit};
    if (w_ret) begin
      w_credit_sum = w_credit_sum + CREDIT_STEP;
    end
    if (w_ack) begin
      w_credit_sum = w_credit_sum - (CW+1)'(1);
    end
    w_credit_ovf = (w_credit_sum > CREDIT_MAX_W);
    w_credit_nxt = w_credit_ovf ? CREDIT_MAX : w_credit_sum[CW-1:0];
  end

  // Sender FSM with registered packet output, address counter, credit counter and sticky overflow flag.
  // The FSM chooses RUN or BLOCKED from the next credit value. This means an arriving credit reopens the handshake on the very next cycle.
  always_ff @(posedge clk_bft) begin
    if (reset) begin
      r_state  <= ST_CFG;
      r_credit <= CREDIT_MAX;
      r_addr   <= '0;
      r_dout   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_credit <= w_credit_nxt;
      if (w_credit_ovf) begin
        r_ovf <= 1'b1;
      end
      case (r_state)
        ST_CFG: begin
          r_dout  <= CFG_PKT;
          r_state <= (w_credit_nxt == '0) ? ST_BLOCKED : ST_RUN;
        end
        ST_RUN, ST_BLOCKED: begin
          r_dout <= w_ack ? w_data_pkt : '0;
          if (w_ack) begin
            r_addr <= r_addr + NUM_ADDR_BITS'(1);
          end
          r_state <= (w_credit_nxt == '0) ? ST_BLOCKED : ST_RUN;
        end
        default: begin
          r_dout  <= '0;
          r_state <= ST_CFG;
        end
      endcase
    end
  end

  assign ack_sender2user = w_ack;
  assign stalled         = w_stalled;
  assign dout_sender2bft = r_dout;
  assign credit_avail    = 8'(r_credit);
  assign err_credit_ovf  = r_ovf;

endmodule

// File: tb/tb_bft_stream_sender.sv
module tb_bft_stream_sender;

  logic        clk_bft = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din_leaf_user2sender = '0;
  logic        vld_user2sender = 1'b0;
  logic        ack_sender2user;
  logic [48:0] dout_sender2bft;
  logic [48:0] din_bft2sender = '0;
  logic [7:0]  credit_avail;
  logic        stalled;
  logic        err_credit_ovf;

  always #5 clk_bft = ~clk_bft;

  bft_stream_sender dut (
    .clk_bft              (clk_bft),
    .reset                (reset),
    .din_leaf_user2sender (din_leaf_user2sender),
    .vld_user2sender      (vld_user2sender),
    .ack_sender2user      (ack_sender2user),
    .dout_sender2bft      (dout_sender2bft),
    .din_bft2sender       (din_bft2sender),
    .credit_avail         (credit_avail),
    .stalled              (stalled),
    .err_credit_ovf       (err_credit_ovf)
  );

  localparam logic [48:0] CREDIT_PKT = 49'h1_0880_0000_0000;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_acks = 0;
  logic [48:0] exp_q[$];

  // Reference model: receiver-side view of the link with plain integers.
  bit m_cfg    = 1'b1;
  int m_credit = 128;
  int m_addr   = 0;
  bit m_ovf    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] cfg_pkt();
    // valid, leaf 2, port 0, addr 0, payload {DST_PORT=2, SELF_LEAF=1, SELF_PORT=1}
    return {1'b1, 5'd2, 4'd0, 7'd0, 19'd0, 4'd2, 5'd1, 4'd1};
  endfunction

  function automatic logic [48:0] data_pkt(input int addr, input logic [31:0] w);
    return {1'b1, 5'd2, 4'd2, 7'(addr), w};
  endfunction

  // One clock of stimulus. Outputs are checked at the falling edge, and then the model is advanced.
  task automatic step(input bit rst, input bit v, input logic [31:0] d, input logic [48:0] b);
    bit e_ack;
    bit e_stall;
    bit ret;
    int sum;
    @(posedge clk_bft);
    #1;
    reset = rst;
    vld_user2sender = v;
    din_leaf_user2sender = d;
    din_bft2sender = b;
    @(negedge clk_bft);
    e_ack   = !rst && !m_cfg && v && (m_credit > 0);
    e_stall = !rst && !m_cfg && v && (m_credit == 0);
    chk("ack", 64'(ack_sender2user), 64'(e_ack));
    chk("stalled", 64'(stalled), 64'(e_stall));
    chk("credit_avail", 64'(credit_avail), 64'(m_credit));
    chk("err_credit_ovf", 64'(err_credit_ovf), 64'(m_ovf));
    if (ack_sender2user === 1'b1) n_acks++;
    if (rst) begin
      m_cfg = 1'b1;
      m_credit = 128;
      m_addr = 0;
      m_ovf = 1'b0;
    end else begin
      ret = b[48] && (b[47:43] == 5'd1) && (b[42:39] == 4'd1);
      if (m_cfg) begin
        exp_q.push_back(cfg_pkt());
        m_cfg = 1'b0;
      end
      sum = m_credit + (ret ? 64 : 0) - (e_ack ? 1 : 0);
      if (sum > 128) begin
        sum = 128;
        m_ovf = 1'b1;
      end
      m_credit = sum;
      if (e_ack) begin
        exp_q.push_back(data_pkt(m_addr, d));
        m_addr = (m_addr + 1) % 128;
      end
    end
  endtask

  // Monitor: every valid packet on the BFT output must be the next one the model queued. Idle cycles must be all zeros.
  initial begin
    logic [48:0] e;
    forever begin
      @(negedge clk_bft);
      if (dout_sender2bft[48] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dout_unexpected: got %0h, expected no packet (t=%0t)", dout_sender2bft, $time);
        end else begin
          e = exp_q.pop_front();
          chk("dout_pkt", 64'(dout_sender2bft), 64'(e));
        end
      end else begin
        chk("dout_idle", 64'(dout_sender2bft), 64'd0);
      end
    end
  end

  function automatic logic [48:0] rand_bft();
    int sel;
    sel = $urandom_range(0, 99);
    if (sel < 1)  return {1'b1, 5'd1, 4'd1, 7'($urandom), 32'($urandom)};
    if (sel < 5)  return {1'b1, 5'($urandom_range(0, 31)), 4'($urandom_range(2, 15)), 7'($urandom), 32'($urandom)};
    if (sel < 8)  return {1'b0, 5'd1, 4'd1, 7'($urandom), 32'($urandom)};
    if (sel < 11) return {1'b1, 5'd2, 4'd1, 7'($urandom), 32'($urandom)};
    return '0;
  endfunction

  initial begin
    // Reset, then config packet with no traffic.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("cfg_pkt", 64'(dout_sender2bft), 64'h1_1000_0000_0411);
    step(0, 0, 0, 0);

    // Two words of 0xDEADBEEF.
    step(0, 1, 32'hDEAD_BEEF, 0);
    step(0, 1, 32'hDEAD_BEEF, 0);
    chk("word0_pkt", 64'(dout_sender2bft), 64'h1_1100_DEAD_BEEF);
    step(0, 0, 0, 0);
    chk("word1_pkt", 64'(dout_sender2bft), 64'h1_1101_DEAD_BEEF);
    chk("credit_126", 64'(credit_avail), 64'd126);

    // Fresh start, then 130 valid words with no credits: exactly 128 acks, then blocked.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    n_acks = 0;
    for (int i = 0; i < 130; i++) step(0, 1, $urandom, 0);
    chk("acks_128", 64'(n_acks), 64'd128);
    chk("blocked_stalled", 64'(stalled), 64'd1);
    chk("blocked_credit", 64'(credit_avail), 64'd0);

    // A credit return reopens the handshake. The next word uses the wrapped address 0.
    step(0, 1, $urandom, CREDIT_PKT);
    step(0, 1, 32'hCAFE_F00D, 0);
    chk("credit_64", 64'(credit_avail), 64'd64);
    chk("resume_ack", 64'(ack_sender2user), 64'd1);
    chk("resume_stalled", 64'(stalled), 64'd0);
    step(0, 0, 0, 0);
    chk("wrap_addr0_pkt", 64'(dout_sender2bft), 64'h1_1100_CAFE_F00D);

    // Credit return in the same cycle as an ack at credit 10.
    while (m_credit > 10) step(0, 1, $urandom, 0);
    step(0, 1, $urandom, CREDIT_PKT);
    step(0, 0, 0, 0);
    chk("credit_73", 64'(credit_avail), 64'd73);

    // Saturation from 100.
    while (m_credit > 36) step(0, 1, $urandom, 0);
    step(0, 0, 0, CREDIT_PKT);
    step(0, 0, 0, CREDIT_PKT);
    chk("credit_100", 64'(credit_avail), 64'd100);
    step(0, 0, 0, 0);
    chk("credit_sat", 64'(credit_avail), 64'd128);
    chk("ovf_set", 64'(err_credit_ovf), 64'd1);
    for (int i = 0; i < 4; i++) step(0, 1, $urandom, 0);
    chk("ovf_sticky", 64'(err_credit_ovf), 64'd1);

    // Reset mid-stream at addr 5.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, $urandom, 0);
    step(1, 1, $urandom, 0);
    step(1, 1, $urandom, 0);
    chk("dout_in_reset", 64'(dout_sender2bft), 64'd0);
    chk("ack_in_reset", 64'(ack_sender2user), 64'd0);
    step(0, 1, $urandom, 0);
    step(0, 1, 32'h1234_5678, 0);
    step(0, 0, 0, 0);
    chk("post_reset_addr0", 64'(dout_sender2bft), 64'h1_1100_1234_5678);
    chk("post_reset_credit", 64'(credit_avail), 64'd127);

    // Random traffic with stray packets, credit returns and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 249) == 0), ($urandom_range(0, 99) < 70), $urandom, rand_bft());
    end

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bft_stream_sender.md
Name: bft_stream_sender

Overview:
Transmit-side counterpart of the leaf interface's user-to-BFT path. It accepts an ap_vld/ap_ack word stream from a host-side or test-side producer and packs each word into a 49-bit BFT packet addressed to one (leaf, port) input of a leaf interface. It emits a one-shot configuration packet after reset and throttles with freespace credits returned over the BFT. It sits at the BFT root or at a traffic-generator leaf.

Parameters:
PACKET_BITS, 49, BFT packet width
PAYLOAD_BITS, 32, data word width
NUM_LEAF_BITS, 5, leaf id field width
NUM_PORT_BITS, 4, port id field width
NUM_ADDR_BITS, 7, receiver BRAM write-address field width
NUM_BRAM_ADDR_BITS, 7, receiver buffer depth = 2^NUM_BRAM_ADDR_BITS words (128)
FREESPACE_UPDATE_SIZE, 64, credits restored per freespace packet
DST_LEAF, 2, destination leaf id
DST_PORT, 2, destination input port id
SELF_LEAF, 1, own leaf id (credit return address)
SELF_PORT, 1, own port id (credit return address)

Ports:
clk_bft  in  1  clock
reset  in  1  synchronous, active-high reset
din_leaf_user2sender  in  32  producer data word
vld_user2sender  in  1  producer word valid
ack_sender2user  out  1  word accepted this cycle
dout_sender2bft  out  49  packet to BFT switch
din_bft2sender  in  49  packet from BFT switch (credit returns)
credit_avail  out  8  current credit count
stalled  out  1  producer valid but blocked by zero credit
err_credit_ovf  out  1  sticky credit-overflow error

Behaviour:
- One clock (clk_bft). Reset is synchronous and active-high, named reset. All state is updated on the rising edge of clk_bft.
- Packet format, MSB first: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload. dout_sender2bft is registered. An idle cycle drives all zeros. The BFT accepts one packet per cycle; there is no backpressure.
- Reset values: dout_sender2bft=0, ack_sender2user=0, stalled=0, err_credit_ovf=0, credit_avail=128, addr counter=0, FSM=CFG. Reset mid-stream discards all counters and re-enters CFG. No partial packet survives reset.
- FSM states:
  - CFG: the first cycle after reset deasserts. Emits the config packet: valid=1, leaf=DST_LEAF, port=0, addr=0, payload[12:9]=DST_PORT, payload[8:4]=SELF_LEAF, payload[3:0]=SELF_PORT, all other bits 0. ack is held 0. Transitions to RUN.
  - RUN: ack_sender2user = vld_user2sender && credit!=0. This path is combinational, ap_ack same-cycle semantics. When credit==0, transitions to BLOCKED.
  - BLOCKED: ack=0. stalled = vld_user2sender. Returns to RUN on the cycle credit becomes nonzero.
- On an acked word: the next cycle dout = {1, DST_LEAF, DST_PORT, addr, word}, so latency is 1. addr then increments mod 2^NUM_ADDR_BITS (127 -> 0). credit decrements by 1.
- Credit return: when din_bft2sender[48]=1, leaf==SELF_LEAF and port==SELF_PORT, credit += FREESPACE_UPDATE_SIZE. The payload of that packet is ignored. Any other incoming packet is ignored.
- Simultaneous send and credit return in one cycle: credit += 64-1.
- If the sum exceeds 128: credit saturates at 128 and err_credit_ovf sets. err_credit_ovf is cleared only by reset.
- credit_avail is credit[7:0]. Its maximum value 128 fits in 8 bits.

Test Plan:
- Release reset, no traffic -> next cycle dout=0x1_1000_0000_0411, then dout=0 on every cycle while vld=0; credit_avail=128.
- vld=1 with 0xDEADBEEF for 2 cycles -> ack=1 on both; dout=0x1_1100_DEAD_BEEF then 0x1_1101_DEAD_BEEF; credit_avail=126.
- Hold vld=1 for 130 words, no credits -> exactly 128 acks; addr wraps 127->0 on the 128th word; then ack=0, stalled=1, credit_avail=0.
- In the blocked state, inject 0x1_0880_0000_0000 -> next cycle credit_avail=64; ack resumes the following cycle; stalled=0.
- Credit packet in the same cycle as an ack with credit=10 -> credit_avail=73. At credit=100, inject a credit packet -> credit_avail=128, err_credit_ovf=1 and stays 1.
- Assert reset mid-stream at addr=5 -> dout=0 and ack=0 during reset; after release, the config packet is re-sent, the first data packet uses addr=0, and credit_avail=128.
